// File: rtl/gpu_sched_pkg.sv
// Shared types and defaults for the operand-collector issue scheduler:
// CDB reservation entry layout, source encodings and pointer helpers.
package gpu_sched_pkg;

    localparam int DEF_NUM_WARPS    = 4;
    localparam int DEF_ALU_LAT      = 1;
    localparam int DEF_MEM_LAT      = 4;
    localparam int DEF_STARVE_LIMIT = 3;

    // Warp id field is sized for the largest supported warp count.
    localparam int WID_MAX_W = 8;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic                 valid;
        logic                 src;
        logic [WID_MAX_W-1:0] wid;
    } wb_entry_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_wb_scheduler_if.sv
// Request/grant and CDB-owner bundle between the warp issue logic and
// the writeback scheduler.
interface cdb_wb_scheduler_if #(
    parameter int NUM_WARPS = 4,
    parameter int WID_W     = $clog2(NUM_WARPS)
);
    logic [NUM_WARPS-1:0] regwrite;
    logic [NUM_WARPS-1:0] alu_req;
    logic [NUM_WARPS-1:0] mem_req;
    logic [NUM_WARPS-1:0] alu_grt;
    logic [NUM_WARPS-1:0] mem_grt;
    logic                 cdb_valid;
    logic                 cdb_src;
    logic [WID_W-1:0]     cdb_wid;
    logic                 starve_active;

    modport master (
        output regwrite, alu_req, mem_req,
        input  alu_grt, mem_grt, cdb_valid, cdb_src, cdb_wid, starve_active
    );

    modport slave (
        input  regwrite, alu_req, mem_req,
        output alu_grt, mem_grt, cdb_valid, cdb_src, cdb_wid, starve_active
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the rotating pointer, the pointer
// moves one past each winner. Grant is combinational and forced low in reset.
module rr_arbiter
    import gpu_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grt
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand_idx;
    logic             found;
    int               cand;

    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= WIDTH) begin
                cand = cand - WIDTH;
            end
            cand_idx = PTR_W'(cand);
            if (!found && req[cand_idx]) begin
                found   = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        grt = '0;
        if (found && rst) begin
            grt[gnt_idx] = 1'b1;
        end
        ptr_next = found ? PTR_W'(next_idx(int'(gnt_idx), WIDTH)) : ptr_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/cdb_wb_scheduler.sv
// ALU/MEM issue scheduler with a calendar of future CDB owners: wb_reg[d]
// owns the CDB d cycles from now, so ALU regwrites never collide with MEM.
module cdb_wb_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int NUM_WARPS    = DEF_NUM_WARPS,
    parameter int ALU_LAT      = DEF_ALU_LAT,
    parameter int MEM_LAT      = DEF_MEM_LAT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int WID_W        = $clog2(NUM_WARPS)
) (
    input logic               clk,
    input logic               rst,
    cdb_wb_scheduler_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    generate
        if (ALU_LAT < 1 || ALU_LAT >= MEM_LAT || MEM_LAT < 2 || STARVE_LIMIT < 1) begin : g_bad_param
            $error("cdb_wb_scheduler: need 1 <= ALU_LAT < MEM_LAT, MEM_LAT >= 2, STARVE_LIMIT >= 1");
        end
    endgenerate

    logic [NUM_WARPS-1:0] alu_qual;
    logic [NUM_WARPS-1:0] mem_qual;
    logic [NUM_WARPS-1:0] alu_grt;
    logic [NUM_WARPS-1:0] mem_grt;
    logic [WID_W-1:0]     alu_wid;
    logic [WID_W-1:0]     mem_wid;
    logic                 alu_rw_grant;
    logic                 mem_rw_grant;
    logic                 alu_rw_req;
    logic                 starve_active;
    logic [CNT_W-1:0]     starve_cnt_reg;
    logic [CNT_W-1:0]     starve_cnt_next;
    wb_entry_t            alu_entry;
    wb_entry_t            wb_reg   [MEM_LAT];
    wb_entry_t            wb_shift [MEM_LAT];
    wb_entry_t            wb_next  [MEM_LAT];

    assign starve_active = (starve_cnt_reg == CNT_MAX);

    // A regwrite ALU op can only issue if its CDB slot is still free.
    assign alu_qual = wb_reg[ALU_LAT].valid ? (bus.alu_req & ~bus.regwrite) : bus.alu_req;
    assign mem_qual = starve_active ? (bus.mem_req & ~bus.regwrite) : bus.mem_req;

    rr_arbiter #(.WIDTH(NUM_WARPS)) u_alu_arb (
        .clk (clk),
        .rst (rst),
        .req (alu_qual),
        .grt (alu_grt)
    );

    rr_arbiter #(.WIDTH(NUM_WARPS)) u_mem_arb (
        .clk (clk),
        .rst (rst),
        .req (mem_qual),
        .grt (mem_grt)
    );

    always_comb begin
        alu_wid = '0;
        mem_wid = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (alu_grt[i]) alu_wid = WID_W'(i);
            if (mem_grt[i]) mem_wid = WID_W'(i);
        end
    end

    assign alu_rw_grant = |(alu_grt & bus.regwrite);
    assign mem_rw_grant = |(mem_grt & bus.regwrite);
    assign alu_rw_req   = |(bus.alu_req & bus.regwrite);
    assign alu_entry    = '{valid: 1'b1, src: SRC_ALU, wid: WID_MAX_W'(alu_wid)};

    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_wb
            if (gi == MEM_LAT - 1) begin : g_tail
                assign wb_shift[gi] = '{valid: mem_rw_grant, src: SRC_MEM, wid: WID_MAX_W'(mem_wid)};
            end else begin : g_body
                assign wb_shift[gi] = wb_reg[gi+1];
            end
            assign wb_next[gi] = (gi == ALU_LAT - 1 && alu_rw_grant) ? alu_entry : wb_shift[gi];
        end
    endgenerate

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (alu_rw_grant || !alu_rw_req) begin
            starve_cnt_next = '0;
        end else if (!starve_active) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                wb_reg[i] <= '0;
            end
            starve_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < MEM_LAT; i++) begin
                wb_reg[i] <= wb_next[i];
            end
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign bus.alu_grt       = alu_grt;
    assign bus.mem_grt       = mem_grt;
    assign bus.starve_active = starve_active;
    assign bus.cdb_valid     = wb_reg[0].valid;
    assign bus.cdb_src       = wb_reg[0].valid & wb_reg[0].src;
    assign bus.cdb_wid       = wb_reg[0].valid ? WID_W'(wb_reg[0].wid) : '0;

endmodule

// File: tb/tb_cdb_wb_scheduler.sv
// Bench for cdb_wb_scheduler: hand vectors, random traffic against a
// cycle-calendar reference model, starvation/reset corners, 5-warp wrap.
module tb_cdb_wb_scheduler;

    localparam int NW      = 4;
    localparam int ALU_LAT = 1;
    localparam int MEM_LAT = 4;
    localparam int LIMIT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdb_wb_scheduler_if #(.NUM_WARPS(4)) bus4 ();
    cdb_wb_scheduler_if #(.NUM_WARPS(5)) bus5 ();

    cdb_wb_scheduler #(
        .NUM_WARPS(NW), .ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(LIMIT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    cdb_wb_scheduler #(
        .NUM_WARPS(5), .ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(LIMIT)
    ) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a calendar of CDB owners indexed by absolute cycle.
    typedef struct {
        bit v;
        bit src;
        int wid;
    } slot_t;

    typedef struct {
        logic [3:0] ea;
        logic [3:0] em;
        bit         v;
        bit         src;
        int         wid;
        bit         st;
    } exp_t;

    slot_t sched [32];
    int    mcyc;
    int    mp_alu;
    int    mp_mem;
    int    mcnt;
    exp_t  ex;

    function automatic logic [4:0] si(input int c);
        return 5'(c);
    endfunction

    function automatic bit bit_of(input logic [3:0] v, input int i);
        return ((v >> i) & 4'd1) != 4'd0;
    endfunction

    function automatic int pick(input logic [3:0] elig, input int ptr);
        for (int k = 0; k < NW; k++) begin
            int w;
            w = (ptr + k) % NW;
            if (bit_of(elig, w)) return w;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) sched[i] = '{0, 0, 0};
        mcyc = 0; mp_alu = 0; mp_mem = 0; mcnt = 0;
    endfunction

    task automatic model_cycle(input logic [3:0] rw, input logic [3:0] ar, input logic [3:0] mr,
                               output exp_t e);
        slot_t      cur;
        logic [3:0] ealu, emem;
        int         ga, gm;
        bit         rwg;
        cur   = sched[si(mcyc)];
        e.v   = cur.v;
        e.src = cur.src;
        e.wid = cur.wid;
        e.st  = (mcnt == LIMIT);
        ealu  = sched[si(mcyc + ALU_LAT)].v ? (ar & ~rw) : ar;
        emem  = e.st ? (mr & ~rw) : mr;
        ga    = pick(ealu, mp_alu);
        gm    = pick(emem, mp_mem);
        e.ea  = (ga >= 0) ? 4'(1 << ga) : 4'd0;
        e.em  = (gm >= 0) ? 4'(1 << gm) : 4'd0;
        sched[si(mcyc)] = '{0, 0, 0};
        if (gm >= 0) begin
            mp_mem = (gm + 1) % NW;
            if (bit_of(rw, gm)) sched[si(mcyc + MEM_LAT)] = '{1, 1, gm};
        end
        rwg = 1'b0;
        if (ga >= 0) begin
            mp_alu = (ga + 1) % NW;
            if (bit_of(rw, ga)) begin
                rwg = 1'b1;
                sched[si(mcyc + ALU_LAT)] = '{1, 0, ga};
            end
        end
        if ((ar & rw) != 4'd0 && !rwg) mcnt = (mcnt < LIMIT) ? mcnt + 1 : LIMIT;
        else mcnt = 0;
        mcyc++;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".alu_grt"}, int'(bus4.alu_grt), int'(ex.ea));
        chk({tag, ".mem_grt"}, int'(bus4.mem_grt), int'(ex.em));
        chk({tag, ".cdb_valid"}, int'(bus4.cdb_valid), int'(ex.v));
        chk({tag, ".starve"}, int'(bus4.starve_active), int'(ex.st));
        if (ex.v) begin
            chk({tag, ".cdb_src"}, int'(bus4.cdb_src), int'(ex.src));
            chk({tag, ".cdb_wid"}, int'(bus4.cdb_wid), ex.wid);
        end
    endtask

    task automatic apply(input logic [3:0] rw, input logic [3:0] ar, input logic [3:0] mr,
                         input bit use_model, input string tag);
        bus4.regwrite = rw;
        bus4.alu_req  = ar;
        bus4.mem_req  = mr;
        #1;
        model_cycle(rw, ar, mr, ex);
        if (use_model) compare_model(tag);
    endtask

    task automatic cycle(input logic [3:0] rw, input logic [3:0] ar, input logic [3:0] mr,
                         input string tag);
        @(negedge clk);
        apply(rw, ar, mr, 1'b1, tag);
    endtask

    typedef struct {
        logic [3:0] rw, ar, mr, ea, em;
        bit         v, src;
        int         wid;
        bit         st;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_grant;
        logic [3:0] rw, ar, mr;

        tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
        tbl[3]  = '{4'b0100, 4'b0110, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
        tbl[6]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 0};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2, 0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 0};
        for (int i = 9; i < 13; i++) tbl[i] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};

        bus4.regwrite = 4'hF; bus4.alu_req = 4'hF; bus4.mem_req = 4'hF;
        bus5.regwrite = '0;   bus5.alu_req = '0;   bus5.mem_req = '0;
        model_reset();

        // Requests held during reset must not be granted.
        repeat (2) @(negedge clk);
        #1;
        chk("reset.alu_grt", int'(bus4.alu_grt), 0);
        chk("reset.mem_grt", int'(bus4.mem_grt), 0);
        chk("reset.cdb_valid", int'(bus4.cdb_valid), 0);
        chk("reset.cdb_src", int'(bus4.cdb_src), 0);
        chk("reset.cdb_wid", int'(bus4.cdb_wid), 0);
        chk("reset.starve", int'(bus4.starve_active), 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst = 1'b1;
                model_reset();
            end
            apply(tbl[i].rw, tbl[i].ar, tbl[i].mr, 1'b0, "tbl");
            chk($sformatf("tbl%0d.alu_grt", i), int'(bus4.alu_grt), int'(tbl[i].ea));
            chk($sformatf("tbl%0d.mem_grt", i), int'(bus4.mem_grt), int'(tbl[i].em));
            chk($sformatf("tbl%0d.cdb_valid", i), int'(bus4.cdb_valid), int'(tbl[i].v));
            chk($sformatf("tbl%0d.starve", i), int'(bus4.starve_active), int'(tbl[i].st));
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d.cdb_src", i), int'(bus4.cdb_src), int'(tbl[i].src));
                chk($sformatf("tbl%0d.cdb_wid", i), int'(bus4.cdb_wid), tbl[i].wid);
            end
            $display("vec %0d rw=%b alu_req=%b mem_req=%b -> alu_grt=%b mem_grt=%b cdb=%b/%b/%0d starve=%b",
                     i, tbl[i].rw, tbl[i].ar, tbl[i].mr, bus4.alu_grt, bus4.mem_grt,
                     bus4.cdb_valid, bus4.cdb_src, bus4.cdb_wid, bus4.starve_active);
        end

        for (int n = 0; n < 400; n++) begin
            rw = 4'($urandom_range(0, 15));
            ar = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            mr = 4'($urandom_range(0, 15));
            cycle(rw, ar, mr, "rnd");
        end
        $display("random phase: %0d cycles, bad so far=%0d", 400, bad);

        // Saturating stream: ALU regwrites starve until MEM regwrites are held off.
        @(negedge clk);
        rst = 1'b0;
        bus4.regwrite = '0; bus4.alu_req = '0; bus4.mem_req = '0;
        #1;
        model_reset();
        chk("stress.reset_cdb", int'(bus4.cdb_valid), 0);
        first_grant = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b1;
            if (k == 7) begin
                rw = 4'b1110; ar = 4'b1110; mr = 4'b0001;
            end else begin
                rw = 4'b1111; ar = 4'b1111; mr = 4'b1111;
            end
            apply(rw, ar, mr, 1'b1, $sformatf("stress%0d", k));
            if (k < 4) chk($sformatf("stress%0d.mem_rot", k), int'(bus4.mem_grt), 1 << k);
            if (k == 3) chk("stress3.alu_blocked", int'(bus4.alu_grt), 0);
            if (k == 5) chk("stress5.starve", int'(bus4.starve_active), 0);
            if (k == 6) begin
                chk("stress6.starve", int'(bus4.starve_active), 1);
                chk("stress6.mem_grt", int'(bus4.mem_grt), 0);
            end
            if (k == 7) begin
                chk("stress7.sw_starve", int'(bus4.starve_active), 1);
                chk("stress7.sw_mem_grt", int'(bus4.mem_grt), 1);
            end
            if (k == 9) chk("stress9.alu_grt", int'(bus4.alu_grt), 8);
            if (k == 11) begin
                chk("stress11.cdb_valid", int'(bus4.cdb_valid), 1);
                chk("stress11.cdb_src", int'(bus4.cdb_src), 0);
                chk("stress11.cdb_wid", int'(bus4.cdb_wid), 0);
            end
            if (k >= 3 && first_grant < 0 && (bus4.alu_grt & rw) != 4'd0) first_grant = k;
            $display("stress %0d alu_grt=%b mem_grt=%b starve=%b cdb=%b/%b/%0d", k, bus4.alu_grt,
                     bus4.mem_grt, bus4.starve_active, bus4.cdb_valid, bus4.cdb_src, bus4.cdb_wid);
        end
        chk("stress.alu_latency_ok", int'(first_grant >= 3 && first_grant - 3 <= LIMIT + MEM_LAT), 1);

        // Reset with three MEM reservations in flight.
        for (int k = 0; k < 3; k++) cycle(4'b1111, 4'b0000, 4'b1111, $sformatf("fill%0d", k));
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst.alu_grt", int'(bus4.alu_grt), 0);
        chk("midrst.mem_grt", int'(bus4.mem_grt), 0);
        chk("midrst.cdb_valid", int'(bus4.cdb_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        apply(4'b0000, 4'b0000, 4'b0000, 1'b1, "post0");
        chk("post0.cdb_valid", int'(bus4.cdb_valid), 0);
        for (int k = 1; k < 6; k++) begin
            cycle(4'b0000, 4'b0000, 4'b0000, $sformatf("post%0d", k));
            chk($sformatf("post%0d.cdb_idle", k), int'(bus4.cdb_valid), 0);
        end
        cycle(4'b0000, 4'b1111, 4'b1111, "resume");
        chk("resume.alu_grt", int'(bus4.alu_grt), 1);
        chk("resume.mem_grt", int'(bus4.mem_grt), 1);
        $display("reset recovery: alu_grt=%b mem_grt=%b", bus4.alu_grt, bus4.mem_grt);

        // Five warps: pointer must wrap from warp 4 back to warp 0.
        bus4.regwrite = '0; bus4.alu_req = '0; bus4.mem_req = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus5.regwrite = 5'b00000;
            bus5.alu_req  = 5'b10001;
            bus5.mem_req  = 5'b10001;
            #1;
            chk($sformatf("w5_%0d.alu_grt", i), int'(bus5.alu_grt), (i % 2 == 0) ? 1 : 16);
            chk($sformatf("w5_%0d.mem_grt", i), int'(bus5.mem_grt), (i % 2 == 0) ? 1 : 16);
            $display("w5 %0d alu_grt=%b mem_grt=%b", i, bus5.alu_grt, bus5.mem_grt);
        end
        chk("w5.cdb_valid", int'(bus5.cdb_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
